// File: rtl/sipo_pkg.sv
// sipo_pkg -- definitions shared by the serial-in/parallel-out receiver.
//   state_t     : receiver frame state (COLLECT data bits, PARITY bit)
//   PARITY_EVEN : XOR over data and parity bits for a clean frame
// The PARITY state is only reached when SIPO_RX_PARITY_EN is defined.
package sipo_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        PARITY  = 1'b1
    } state_t;

    // Even parity: the XOR of all data bits and the parity bit is 0.
    localparam logic PARITY_EVEN = 1'b0;

endpackage

// File: rtl/sipo_rx_bit_counter.sv
// bit_counter -- frame bit position counter, counts 0..TERMINAL and wraps.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset, forces count to 0
//   clear   : synchronous clear to 0, priority over inc
//   inc     : advance by one (wrap to 0 from TERMINAL)
//   at_last : count currently equals TERMINAL
module bit_counter #(
    parameter int TERMINAL = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic at_last
);

    localparam int CW = (TERMINAL < 1) ? 1 : $clog2(TERMINAL + 1);

    logic [CW-1:0] count;

    assign at_last = (count == CW'(TERMINAL));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= at_last ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// sipo_rx -- serial-in/parallel-out receiver with one-word output holding
// register and valid/ready handshake.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (highest priority)
//   en        : bit-sample enable
//   ser       : serial data, LSB first
//   sync      : frame restart, discards a partial word (priority over en)
//   dout      : assembled word (registered)
//   out_valid : dout holds an undelivered word
//   out_ready : consumer accepts dout when out_valid=1
//   overrun   : one-cycle pulse when a completed word is dropped
//   par_err   : parity error for the word in dout, qualified by out_valid
// Build option: define SIPO_RX_PARITY_EN to append one even-parity bit to
// every frame; otherwise frames are WIDTH bits and par_err stays 0.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ser,
    input  logic             sync,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             par_err
);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             sample;
    logic             shift_en;
    logic             at_last;
    logic             word_done;
    logic             word_perr;

    // sync wins over en: nothing is sampled on a restart edge.
    assign sample  = en & ~sync;
    // LSB first: new bits enter at the top and walk down to bit 0.
    assign shifted = {ser, shreg[WIDTH-1:1]};

`ifdef SIPO_RX_PARITY_EN
    state_t state;

    // Data bits only shift in COLLECT; the parity bit is checked but not stored.
    assign shift_en  = sample && (state == COLLECT);
    assign word_done = sample && (state == PARITY);
    assign word      = shreg;
    assign word_perr = ((^shreg) ^ ser) != PARITY_EVEN;

    always_ff @(posedge clk) begin
        if (rst || sync) begin
            state <= COLLECT;
        end else if (sample) begin
            if (state == COLLECT && at_last) begin
                state <= PARITY;
            end else if (state == PARITY) begin
                state <= COLLECT;
            end
        end
    end
`else
    assign shift_en  = sample;
    assign word_done = sample && at_last;
    assign word      = shifted;
    assign word_perr = 1'b0;
`endif

    bit_counter #(
        .TERMINAL(WIDTH - 1)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (sync),
        .inc    (shift_en),
        .at_last(at_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= shifted;
        end
    end

    // Output holding register: a completed word loads when the slot is free
    // or being accepted on this same edge; otherwise it is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout      <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (word_done) begin
                if (!out_valid || out_ready) begin
                    dout      <= word;
                    par_err   <= word_perr;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx -- self-checking bench for sipo_rx (WIDTH=8).
// Expected words are queued as frames are sent and compared when the
// consumer accepts them; each scenario also checks flags inline.
module tb_sipo_rx;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic         ser;
    logic         sync;
    logic [W-1:0] dout;
    logic         out_valid;
    logic         out_ready;
    logic         overrun;
    logic         par_err;

    typedef struct packed {
        logic [W-1:0] w;
        logic         p;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors;
    int   miscompares;
    bit   mon_on;

    sipo_rx #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .ser      (ser),
        .sync     (sync),
        .dout     (dout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun),
        .par_err  (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: an accept happens on the next rising edge whenever
    // out_valid and out_ready are both high and reset is not asserted.
    always @(negedge clk) begin
        if (mon_on && !rst && out_valid && out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_word dout=%h (no word expected)", dout);
            end else begin
                mon_e = sb.pop_front();
                if (dout !== mon_e.w || par_err !== mon_e.p) begin
                    miscompares++;
                    $display("FAIL sb_word dout=%h par_err=%b expected dout=%h par_err=%b",
                             dout, par_err, mon_e.w, mon_e.p);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Sends nbits data bits of w (LSB first); when full=1 and the parity build
    // is active, also sends pbit. ready_last raises out_ready on the final edge.
    task automatic send_frame(input logic [W-1:0] w, input int nbits, input bit full,
                              input bit ready_last, input bit toggle_en, input logic pbit);
        bit last;
        for (int i = 0; i < nbits; i++) begin
            if (toggle_en) begin
                en  = 1'b0;
                ser = ~w[i];
                tick();
            end
            last = 1'b0;
`ifndef SIPO_RX_PARITY_EN
            last = full && (i == nbits - 1);
`endif
            en  = 1'b1;
            ser = w[i];
            if (last && ready_last) out_ready = 1'b1;
            tick();
        end
`ifdef SIPO_RX_PARITY_EN
        if (full) begin
            if (toggle_en) begin
                en = 1'b0;
                tick();
            end
            en  = 1'b1;
            ser = pbit;
            if (ready_last) out_ready = 1'b1;
            tick();
        end
`endif
        en  = 1'b0;
        ser = 1'b0;
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; sync = 1'b1; out_ready = 1'b1; ser = 1'b1;
        tick();
        tick();
        vectors++;
        if (dout !== 8'h00 || out_valid !== 1'b0 || overrun !== 1'b0 || par_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs dout=%h valid=%b ovr=%b perr=%b expected all 0",
                     dout, out_valid, overrun, par_err);
        end
        rst = 1'b0; en = 1'b0; sync = 1'b0; out_ready = 1'b0; ser = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        sync = 1'b1; en = 1'b1; ser = 1'b1;
        tick();
        sync = 1'b0;
        sb.push_back('{w: 8'hA5, p: 1'b0});
        send_frame(8'hA5, W, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (dout !== 8'hA5) begin
            miscompares++;
            $display("FAIL basic_dout got=%h expected=a5", dout);
        end
        check_bit("basic_valid_set", out_valid, 1'b1);
        idle(1);
        check_bit("basic_valid_one_cycle", out_valid, 1'b0);
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        sb.push_back('{w: 8'h3C, p: 1'b0});
        send_frame(8'h3C, W, 1'b1, 1'b0, 1'b0, 1'b0);
        check_bit("ovr_first_valid", out_valid, 1'b1);
        check_bit("ovr_no_pulse_first", overrun, 1'b0);
        send_frame(8'hFF, W, 1'b1, 1'b0, 1'b0, 1'b0);
        check_bit("ovr_pulse", overrun, 1'b1);
        vectors++;
        if (dout !== 8'h3C) begin
            miscompares++;
            $display("FAIL ovr_dout_held got=%h expected=3c", dout);
        end
        idle(1);
        check_bit("ovr_pulse_one_cycle", overrun, 1'b0);
        check_bit("ovr_valid_held", out_valid, 1'b1);
    endtask

    task automatic test_accept_on_completion();
        // 0x3C still pending from the overrun scenario.
        sb.push_back('{w: 8'h96, p: 1'b0});
        send_frame(8'h96, W, 1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (dout !== 8'h96) begin
            miscompares++;
            $display("FAIL aoc_dout got=%h expected=96", dout);
        end
        check_bit("aoc_valid_stays", out_valid, 1'b1);
        check_bit("aoc_no_overrun", overrun, 1'b0);
        idle(1);
        check_bit("aoc_drained", out_valid, 1'b0);
    endtask

    task automatic test_sync();
        out_ready = 1'b1;
        send_frame(8'hFF, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        sync = 1'b1; en = 1'b1; ser = 1'b1;
        tick();
        sync = 1'b0;
        check_bit("sync_no_valid", out_valid, 1'b0);
        sb.push_back('{w: 8'h81, p: 1'b0});
        send_frame(8'h81, W, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (dout !== 8'h81) begin
            miscompares++;
            $display("FAIL sync_dout got=%h expected=81", dout);
        end
        idle(1);
    endtask

    task automatic test_en_toggle();
        out_ready = 1'b1;
        sb.push_back('{w: 8'h5A, p: 1'b0});
        send_frame(8'h5A, W, 1'b1, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (dout !== 8'h5A || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL en_toggle got=%h valid=%b expected=5a valid=1", dout, out_valid);
        end
        idle(1);
    endtask

`ifdef SIPO_RX_PARITY_EN
    task automatic test_parity();
        out_ready = 1'b1;
        sb.push_back('{w: 8'h07, p: 1'b0});
        send_frame(8'h07, W, 1'b1, 1'b0, 1'b0, 1'b1);
        check_bit("parity_good", par_err, 1'b0);
        idle(1);
        sb.push_back('{w: 8'h07, p: 1'b1});
        send_frame(8'h07, W, 1'b1, 1'b0, 1'b0, 1'b0);
        check_bit("parity_bad", par_err, 1'b1);
        idle(1);
    endtask
`endif

    task automatic test_reset_midframe();
        out_ready = 1'b0;
        send_frame(8'h11, W, 1'b1, 1'b0, 1'b0, 1'b0);
        check_bit("rmf_valid_before", out_valid, 1'b1);
        send_frame(8'hFF, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; en = 1'b1; ser = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        vectors++;
        if (dout !== 8'h00 || out_valid !== 1'b0 || overrun !== 1'b0 || par_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rmf_outputs dout=%h valid=%b ovr=%b perr=%b expected all 0",
                     dout, out_valid, overrun, par_err);
        end
        // Partial bits must be gone: a fresh frame assembles cleanly.
        out_ready = 1'b1;
        sb.push_back('{w: 8'h22, p: 1'b0});
        send_frame(8'h22, W, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (dout !== 8'h22) begin
            miscompares++;
            $display("FAIL rmf_fresh_word got=%h expected=22", dout);
        end
        check_bit("rmf_no_overrun", overrun, 1'b0);
        idle(2);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        mon_on = 1'b0;
        rst = 1'b1; en = 1'b0; ser = 1'b0; sync = 1'b0; out_ready = 1'b0;
        test_reset();
        mon_on = 1'b1;
        test_basic();
        test_overrun();
        test_accept_on_completion();
        test_sync();
        test_en_toggle();
`ifdef SIPO_RX_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover words=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
